// File: rtl/clkdiv_pkg.sv
// Shared widths, reset defaults and the configuration request type for clkdiv_nco.
// The accumulator width is set here and applies to every channel.
package clkdiv_pkg;

  localparam int CLK_ACC_W = 16;
  localparam int CH_W      = 3;

  localparam logic [CLK_ACC_W-1:0] CLK_DEF_NUM = CLK_ACC_W'(1);
  localparam logic [CLK_ACC_W-1:0] CLK_DEF_DEN = CLK_ACC_W'(25);

  typedef struct packed {
    logic                 en;
    logic [CLK_ACC_W-1:0] num;
    logic [CLK_ACC_W-1:0] den;
  } cfg_req_t;

  // A disabled request carries no ratio, so only DEN = 0 can make it bad.
  function automatic logic cfg_reject(cfg_req_t r);
    return (r.den == '0) || (r.en && (r.num > r.den));
  endfunction

endpackage

// File: rtl/clkdiv_nco_if.sv
// Configuration bus of clkdiv_nco: valid/ready request plus a registered error pulse.
interface clkdiv_nco_if;
  import clkdiv_pkg::*;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic                 cfg_en;
  logic [CLK_ACC_W-1:0] cfg_num;
  logic [CLK_ACC_W-1:0] cfg_den;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_num, cfg_den,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_num, cfg_den,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clkdiv_channel.sv
// One NCO channel: accumulator emitting cen at NUM/DEN of the clock, plus a
// one-entry shadow that swaps in at the next pulse (or at once when idle).
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter logic [CLK_ACC_W-1:0] DEF_NUM = CLK_DEF_NUM,
  parameter logic [CLK_ACC_W-1:0] DEF_DEN = CLK_DEF_DEN,
  parameter logic                 DEF_EN  = 1'b1
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     sync_i,
  input  logic     wr_i,
  input  cfg_req_t req_i,
  output logic     cen_o,
  output logic     clk_out_o,
  output logic     p_valid_o
);

  logic [CLK_ACC_W-1:0] acc_q, acc_d;
  cfg_req_t             cur_q, cur_d;
  cfg_req_t             pend_q, pend_d;
  logic                 pv_q, pv_d;
  logic                 cen_q, cen_d;
  logic                 clk_out_q, clk_out_d;

  logic [CLK_ACC_W:0]   sum;
  logic                 pulse;
  logic                 apply;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    acc_d     = acc_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    pv_d      = pv_q;
    clk_out_d = clk_out_q;

    sum   = {1'b0, acc_q} + {1'b0, cur_q.num};
    pulse = cur_q.en && (cur_q.num != '0) && (sum >= {1'b0, cur_q.den});
    apply = pv_q && (pulse || !cur_q.en || (cur_q.num == '0));
    cen_d = pulse;

    if (!cur_q.en) begin
      acc_d     = '0;
      clk_out_d = 1'b0;
    end else if (pulse) begin
      // acc < den and num <= den, so the true result fits ACC_W bits.
      acc_d     = acc_q + cur_q.num - cur_q.den;
      clk_out_d = ~clk_out_q;
    end else begin
      acc_d = sum[CLK_ACC_W-1:0];
    end

    if (sync_i) begin
      acc_d     = '0;
      clk_out_d = 1'b0;
      cen_d     = 1'b0;
    end

    // The pulse of this cycle already used the old ratio; the new one starts from zero.
    if (apply) begin
      cur_d = pend_q;
      acc_d = '0;
      pv_d  = 1'b0;
    end

    // The top only writes when the shadow is free, so this never races apply.
    if (wr_i) begin
      pend_d = req_i;
      pv_d   = 1'b1;
    end
  end

  // NOTE: clocked blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      cur_q     <= '{en: DEF_EN, num: DEF_NUM, den: DEF_DEN};
      pv_q      <= 1'b0;
      cen_q     <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cur_q     <= cur_d;
      pv_q      <= pv_d;
      cen_q     <= cen_d;
      clk_out_q <= clk_out_d;
    end
  end

  // NOTE: the shadow payload is not reset; pv_q alone says whether it is meaningful.
  always_ff @(posedge clk_i) begin
    pend_q <= pend_d;
  end

  assign cen_o     = cen_q;
  assign clk_out_o = clk_out_q;
  assign p_valid_o = pv_q;

endmodule

// File: rtl/clkdiv_nco.sv
// Multi-channel programmable clock-enable generator: config decode/validation,
// ready mux and error pulse around CHANNELS independent NCO channels.
module clkdiv_nco
  import clkdiv_pkg::*;
#(
  parameter int                   CHANNELS = 2,
  parameter logic [CLK_ACC_W-1:0] DEF_NUM  = CLK_DEF_NUM,
  parameter logic [CLK_ACC_W-1:0] DEF_DEN  = CLK_DEF_DEN,
  parameter logic [CHANNELS-1:0]  DEF_EN   = '1
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  input  logic                sync,
  clkdiv_nco_if.slave         cfg,
  output logic [CHANNELS-1:0] cen,
  output logic [CHANNELS-1:0] clk_out
);

  cfg_req_t            req;
  logic [CHANNELS-1:0] p_valid;
  logic [CHANNELS-1:0] wr;
  logic                ch_hit;
  logic                reject;
  logic                accept;
  logic                cfg_err_q, cfg_err_d;

  assign req = '{en: cfg.cfg_en, num: cfg.cfg_num, den: cfg.cfg_den};

  // Out-of-range channels are always ready so a bad request cannot stall the bus.
  always_comb begin
    ch_hit        = 1'b0;
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ch_hit        = 1'b1;
        cfg.cfg_ready = !p_valid[i];
      end
    end
  end

  assign accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign reject    = !ch_hit || cfg_reject(req);
  assign cfg_err_d = accept && reject;

  always_comb begin
    wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = accept && !reject && (cfg.cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= cfg_err_d;
  end

  assign cfg.cfg_err = cfg_err_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clkdiv_channel #(
      .DEF_NUM (DEF_NUM),
      .DEF_DEN (DEF_DEN),
      .DEF_EN  (DEF_EN[g])
    ) u_ch (
      .clk_i     (clk_100mhz),
      .reset_i   (reset),
      .sync_i    (sync),
      .wr_i      (wr[g]),
      .req_i     (req),
      .cen_o     (cen[g]),
      .clk_out_o (clk_out[g]),
      .p_valid_o (p_valid[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_nco.sv
// Bench for clkdiv_nco: a cycle model feeds a scoreboard of expected outputs,
// plus directed checks of pulse timing, handshake, errors, sync and reset.
module tb_clkdiv_nco;
  import clkdiv_pkg::*;

  localparam int CH = 2;

  logic          clk_100mhz = 1'b0;
  logic          reset      = 1'b1;
  logic          sync       = 1'b0;
  logic [CH-1:0] cen, clk_out;

  clkdiv_nco_if bus ();

  clkdiv_nco #(.CHANNELS(CH)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .sync       (sync),
    .cfg        (bus.slave),
    .cen        (cen),
    .clk_out    (clk_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic          err;
    logic [CH-1:0] clk;
    logic [CH-1:0] cen;
  } obs_t;

  obs_t sb_q[$];

  int m_acc[CH], m_num[CH], m_den[CH], p_num[CH], p_den[CH];
  bit m_en[CH], m_pv[CH], p_en[CH], m_cen[CH], m_clk[CH];
  bit m_err;

  function automatic bit m_ready(int ch);
    return (ch >= CH) ? 1'b1 : !m_pv[ch];
  endfunction

  always @(posedge clk_100mhz) begin : model
    bit   take, bad, fire, due;
    int   ch, s;
    obs_t e;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_num[c] = 1; m_den[c] = 25; m_en[c] = 1'b1;
        m_pv[c] = 1'b0; m_cen[c] = 1'b0; m_clk[c] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      ch   = int'(bus.cfg_ch);
      take = bus.cfg_valid && m_ready(ch);
      bad  = (ch >= CH) || (bus.cfg_den == 0) || (bus.cfg_en && (bus.cfg_num > bus.cfg_den));
      for (int c = 0; c < CH; c++) begin
        s    = m_acc[c] + m_num[c];
        fire = m_en[c] && (m_num[c] > 0) && (s >= m_den[c]);
        due  = m_pv[c] && (fire || !m_en[c] || (m_num[c] == 0));
        m_cen[c] = fire && !sync;
        if (sync || !m_en[c]) begin
          m_acc[c] = 0;
          m_clk[c] = 1'b0;
        end else if (fire) begin
          m_acc[c] = s - m_den[c];
          m_clk[c] = !m_clk[c];
        end else begin
          m_acc[c] = s;
        end
        if (due) begin
          m_num[c] = p_num[c]; m_den[c] = p_den[c]; m_en[c] = p_en[c];
          m_acc[c] = 0; m_pv[c] = 1'b0;
        end
      end
      if (take && !bad) begin
        m_pv[ch] = 1'b1; p_num[ch] = int'(bus.cfg_num);
        p_den[ch] = int'(bus.cfg_den); p_en[ch] = bus.cfg_en;
      end
      m_err = take && bad;
    end
    e.err = m_err;
    for (int c = 0; c < CH; c++) begin
      e.clk[c] = m_clk[c];
      e.cen[c] = m_cen[c];
    end
    sb_q.push_back(e);
  end

  always @(negedge clk_100mhz) begin : scoreboard
    obs_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("sb_cen", cen, e.cen);
      check("sb_clk_out", clk_out, e.clk);
      check("sb_cfg_err", bus.cfg_err, e.err);
    end
  end

  // Rising edges since reset deassertion; read on the falling edge.
  int cyc = 0;
  always @(posedge clk_100mhz) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // ---------------- stimulus helpers ----------------
  int last_acc  = 0;
  int last_wait = 0;

  task automatic tick();
    @(negedge clk_100mhz);
  endtask

  task automatic cfg_send(input int ch, input bit en, input int num, input int den,
                          input bit exp_err);
    int w;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_en    = en;
    bus.cfg_num   = CLK_ACC_W'(num);
    bus.cfg_den   = CLK_ACC_W'(den);
    bus.cfg_valid = 1'b1;
    w = 0;
    #1;
    while (!bus.cfg_ready && w < 300) begin
      tick();
      #1;
      w++;
    end
    last_wait = w;
    check("cfg_wait_bound", w < 300, 1);
    check("cfg_ready", bus.cfg_ready, m_ready(ch));
    tick();
    last_acc      = cyc;
    bus.cfg_valid = 1'b0;
    check("cfg_err_pulse", bus.cfg_err, exp_err);
    tick();
    check("cfg_err_drop", bus.cfg_err, 0);
  endtask

  task automatic wait_ready(input int ch, output int t);
    int w;
    bus.cfg_ch = CH_W'(ch);
    w = 0;
    #1;
    while (!bus.cfg_ready && w < 300) begin
      tick();
      #1;
      w++;
    end
    check("ready_bound", w < 300, 1);
    t = cyc;
  endtask

  task automatic wait_pulse(input int c, output int t);
    int w;
    w = 0;
    do begin
      tick();
      w++;
    end while (!cen[c] && w < 300);
    check("pulse_bound", w < 300, 1);
    t = cyc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int np, n0, n1, bad_gap, bad_win, last1, t, t1, t2, sum;
    bit win[$];

    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_en    = 1'b0;
    bus.cfg_num   = '0;
    bus.cfg_den   = '0;

    repeat (3) tick();
    check("rst_cen", cen, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    reset = 1'b0;

    // Defaults 1/25.
    np = 0; n0 = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (cen[0]) begin
        n0++;
        if (np < 3) begin
          check("dflt_pulse_cycle", cyc, 25 * (np + 1));
          check("dflt_clk_toggle", clk_out[0], (np + 1) % 2);
          np++;
        end
      end
    end
    check("dflt_count_1000", n0, 40);

    // ch1 -> 3/10, ch0 stays 1/25.
    cfg_send(1, 1'b1, 3, 10, 1'b0);
    wait_ready(1, t);
    last1 = t; n0 = 0; n1 = 0; bad_gap = 0; bad_win = 0;
    for (int k = 0; k < 10000; k++) begin
      tick();
      if (cen[0]) n0++;
      win.push_back(cen[1]);
      if (win.size() > 10) void'(win.pop_front());
      if (win.size() == 10) begin
        sum = 0;
        foreach (win[i]) sum += int'(win[i]);
        if (sum != 3) bad_win++;
      end
      if (cen[1]) begin
        n1++;
        if (!((cyc - last1) inside {3, 4})) bad_gap++;
        last1 = cyc;
      end
    end
    check("r3_10_count", n1, 3000);
    check("r3_10_windows", bad_win, 0);
    check("r3_10_spacing", bad_gap, 0);
    check("ch0_unaffected", n0, 400);

    // Back-to-back to ch0: second request waits for the first to apply.
    bus.cfg_ch = CH_W'(0); bus.cfg_en = 1'b1;
    bus.cfg_num = CLK_ACC_W'(2); bus.cfg_den = CLK_ACC_W'(10);
    bus.cfg_valid = 1'b1;
    #1;
    check("b2b_first_ready", bus.cfg_ready, 1);
    tick();
    #1;
    check("b2b_pending_ready", bus.cfg_ready, 0);
    cfg_send(0, 1'b1, 1, 5, 1'b0);
    check("b2b_second_waited", last_wait > 0, 1);
    wait_ready(0, t);
    wait_pulse(0, t1);
    check("b2b_new_rate_first", t1 - t, 5);
    wait_pulse(0, t2);
    check("b2b_new_rate_gap", t2 - t1, 5);

    // Rejected requests: no pending shadow, rate unchanged.
    cfg_send(0, 1'b1, 1, 0, 1'b1);
    #1; check("err_den0_no_pend", bus.cfg_ready, 1);
    cfg_send(0, 1'b1, 5, 4, 1'b1);
    #1; check("err_num_gt_den_no_pend", bus.cfg_ready, 1);
    cfg_send(7, 1'b1, 1, 2, 1'b1);
    bus.cfg_ch = CH_W'(0);
    #1; check("err_bad_ch_no_pend", bus.cfg_ready, 1);
    wait_pulse(0, t1);
    wait_pulse(0, t2);
    check("err_rate_kept", t2 - t1, 5);

    // sync on the edge where ch0 is due to pulse.
    t = 0;
    while (!(m_en[0] && m_num[0] > 0 && (m_acc[0] + m_num[0] >= m_den[0])) && t < 50) begin
      tick();
      t++;
    end
    check("sync_due_bound", t < 50, 1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_cen_suppressed", cen[0], 0);
    check("sync_clk_out_low", clk_out, 0);
    t = cyc;
    wait_pulse(0, t1);
    check("sync_next_pulse", t1 - t, 5);

    // Disable ch0, then re-enable at 1/4.
    cfg_send(0, 1'b0, 1, 4, 1'b0);
    wait_ready(0, t);
    bad_gap = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cen[0] || clk_out[0]) bad_gap++;
    end
    check("disabled_quiet", bad_gap, 0);
    cfg_send(0, 1'b1, 1, 4, 1'b0);
    #1; check("enable_applied_next", bus.cfg_ready, 1);
    wait_pulse(0, t1);
    check("enable_first_pulse", t1 - last_acc, 5);

    // Reset with a pending shadow on ch1 discards it.
    bus.cfg_ch = CH_W'(1); bus.cfg_en = 1'b1;
    bus.cfg_num = CLK_ACC_W'(1); bus.cfg_den = CLK_ACC_W'(10);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    #1; check("rst_pend_before", bus.cfg_ready, 0);
    reset = 1'b1;
    tick();
    #1; check("rst_pend_cleared", bus.cfg_ready, 1);
    reset = 1'b0;
    wait_pulse(1, t1);
    check("rst_default_rate", t1, 25);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_nco.md
# clkdiv_nco

Multi-channel, runtime-programmable clock-enable generator, the parametrised successor to the fixed single-output divider. Each channel is a Bresenham/NCO accumulator producing pulses at f_clk·NUM/DEN, so integer and non-integer ratios are handled by one mechanism (e.g. 100 MHz → 7.67 MHz for the FM core). It sits at the top level next to the board clock and drives clock enables and toggled square waves for downstream cores.

## Interface
- CHANNELS, 2, number of independent channels (1..8)
- ACC_W, 16, accumulator/NUM/DEN width
- DEF_NUM, 1, NUM loaded into every channel at reset
- DEF_DEN, 25, DEN loaded into every channel at reset
- DEF_EN, all ones, per-channel enable at reset

- clk_100mhz  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- sync  in  1  one-cycle phase-align strobe for all channels
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept (combinational on cfg_ch)
- cfg_ch  in  3  target channel
- cfg_en  in  1  new enable for the target channel
- cfg_num  in  ACC_W  new NUM
- cfg_den  in  ACC_W  new DEN
- cfg_err  out  1  one-cycle pulse: request was rejected
- cen  out  CHANNELS  one-cycle enable pulse per channel
- clk_out  out  CHANNELS  square wave, toggles on every cen pulse

## Operation
- Per channel: registers acc, num, den, en, plus a one-entry pending shadow (p_valid, p_num, p_den, p_en).
- Each cycle, for an enabled channel: sum = acc + num, computed at ACC_W+1 bits with no overflow. If sum ≥ den then acc ← sum − den, cen ← 1, clk_out toggles. Otherwise acc ← sum and cen ← 0.
- num = 0: channel enabled but silent. acc holds and cen stays 0.
- Disabled channel: acc ← 0, cen ← 0, clk_out ← 0.
- Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready = !p_valid[cfg_ch]. For cfg_ch ≥ CHANNELS, cfg_ready = 1.
- Rejected requests: cfg_ch ≥ CHANNELS, or cfg_den = 0, or cfg_num > cfg_den (checked only when cfg_en = 1). These are accepted, then dropped. cfg_err pulses on the next cycle and no state changes.
- Valid requests fill the shadow (p_valid ← 1).
- Apply point: the shadow is applied on the channel's next cen cycle. If the channel is disabled or num = 0, it is applied on the next cycle. On apply: num/den/en ← shadow, acc ← 0, p_valid ← 0. The pulse in the apply cycle uses the old values.
- sync = 1: all channels get acc ← 0, clk_out ← 0, cen ← 0. sync overrides a pulse in the same cycle. A pending apply due in that cycle still happens.
- reset: acc = 0, num = DEF_NUM, den = DEF_DEN, en = DEF_EN, p_valid = 0, cen = 0, clk_out = 0, cfg_err = 0.

## Timing
- All outputs are registered.
- From reset deassertion with NUM = 1, DEN = 25: first cen at the 25th rising edge, then every 25 cycles. clk_out period is 50 cycles.
- General case: over any DEN consecutive cycles there are exactly NUM pulses. Pulse spacing is floor or ceil of DEN/NUM.
- Config latency: the shadow is written at the accept edge. The earliest apply is the following edge. The new rate counts from acc = 0 after the apply edge.
- cfg_err asserts exactly one cycle after a rejected accept.
- Reset mid-operation discards pending shadows.

## Structure
- Package clkdiv_pkg holds: ACC_W default, DEF_NUM/DEF_DEN defaults, the channel-index width, and a cfg_req struct (en, num, den).
- Sub-module clkdiv_channel: one accumulator plus its shadow. It is instantiated CHANNELS times by a generate loop.
- Top-level logic: cfg decode/validation, cfg_ready mux, cfg_err register.

## Test plan
- Reset, defaults 1/25: cen at cycles 25, 50, 75; clk_out toggles at each; 40 pulses in 1000 cycles.
- Program ch1 NUM = 3, DEN = 10: exactly 3 pulses per 10 cycles, spacings in {3, 4}, over 10 000 cycles. ch0 is unaffected.
- Two back-to-back configs to ch0 while its shadow is pending: the second waits (cfg_ready = 0) until the apply edge, then is accepted.
- cfg_den = 0, cfg_num = 5 with cfg_den = 4, and cfg_ch = 7 with CHANNELS = 2: each gives a cfg_err pulse one cycle later and no rate change.
- sync asserted in the same cycle as a due pulse on ch0: no cen that cycle, clk_out = 0, next pulse DEN/NUM cycles later.
- Disable ch0 via cfg_en = 0: applied next cycle, cen/clk_out held 0. Re-enable with 1/4: first pulse 4 cycles after the apply edge.
